// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants (as emitted by the ALU control
//               decoder) and the alu_exec FSM state encoding.
//               Optional divider build: define ALU_EXEC_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] C_OP_ADD  = 4'b0000;
  localparam logic [3:0] C_OP_SUB  = 4'b0001;
  localparam logic [3:0] C_OP_MUL  = 4'b0011;
  localparam logic [3:0] C_OP_DIV  = 4'b0100;
  localparam logic [3:0] C_OP_SHL  = 4'b0101;
  localparam logic [3:0] C_OP_SHR  = 4'b0110;
  localparam logic [3:0] C_OP_ROTL = 4'b0111;
  localparam logic [3:0] C_OP_ROTR = 4'b1000;
  localparam logic [3:0] C_OP_ADDA = 4'b1001;
  localparam logic [3:0] C_OP_SUBB = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
`ifdef ALU_EXEC_DIV_EN
    S_DIV  = 3'd3,
`endif
    S_DONE = 3'd4
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// ============================================================================
// Module      : alu_seq_muldiv
// Description : Iterative unsigned engine, one bit per cycle for WIDTH cycles.
//               Shift-add multiply by default; restoring divide is compiled
//               in when ALU_EXEC_DIV_EN is defined. o_done is high during the
//               last iteration cycle, and o_lo/o_hi then carry the final
//               values (they show the result of the step being taken).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
`ifdef ALU_EXEC_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;    // partial product high half / partial remainder
  logic [WIDTH-1:0]   r_lo;    // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0]   r_opd;   // multiplicand / divisor
`ifdef ALU_EXEC_DIV_EN
  logic               r_div;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
`endif
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_nxt_hi;
  logic [WIDTH-1:0]   w_nxt_lo;

  // One iteration step: add-then-shift-right for multiply, shift-then-trial-subtract for divide
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    w_prod   = {w_sum, r_lo[WIDTH-1:1]};
    w_nxt_hi = w_prod[2*WIDTH-1:WIDTH];
    w_nxt_lo = w_prod[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_trial  = w_shift - {1'b0, r_opd};
    if (r_div) begin
      if (w_trial[WIDTH]) begin
        // trial went negative: restore, quotient bit 0
        w_nxt_hi = w_shift[WIDTH-1:0];
        w_nxt_lo = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_nxt_hi = w_trial[WIDTH-1:0];
        w_nxt_lo = {r_lo[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH-1));
  assign o_lo   = w_nxt_lo;
  assign o_hi   = w_nxt_hi;

  // Load operands on start, then iterate until the last step is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opd  <= '0;
`ifdef ALU_EXEC_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= i_a;
      r_opd  <= i_b;
`ifdef ALU_EXEC_DIV_EN
      r_div  <= i_div;
`endif
    end else if (r_busy) begin
      r_hi  <= w_nxt_hi;
      r_lo  <= w_nxt_lo;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module      : alu_exec
// Description : Multi-cycle ALU execute stage. Single-cycle add/sub/shift/
//               rotate on the EXEC path, iterative multiply (and divide when
//               ALU_EXEC_DIV_EN is defined) through alu_seq_muldiv.
//               Results are registered on entry to DONE and held until the
//               next done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               ROT_W        = $clog2(WIDTH);
  localparam logic [ROT_W:0]   C_ROT_SPAN   = (ROT_W+1)'(WIDTH);
  localparam logic [WIDTH-1:0] C_SHIFT_LIM  = WIDTH'(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_err;

  logic [WIDTH-1:0] w_exec_res;
  logic [WIDTH-1:0] w_exec_hi;
  logic             w_exec_err;
  logic [ROT_W-1:0] w_rot_amt;
  logic [ROT_W:0]   w_rot_inv;
  logic             w_shift_big;

  logic             w_sub_start;
  logic             w_sub_done;
  logic [WIDTH-1:0] w_sub_lo;
  logic [WIDTH-1:0] w_sub_hi;
`ifdef ALU_EXEC_DIV_EN
  logic             w_sub_div;
  assign w_sub_div = (alu_control == C_OP_DIV);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; divide by zero skips the engine and takes the EXEC path
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (alu_control == C_OP_MUL) w_next_state = S_MUL;
`ifdef ALU_EXEC_DIV_EN
          else if (alu_control == C_OP_DIV && b != '0) w_next_state = S_DIV;
`endif
          else w_next_state = S_EXEC;
        end
      end
      S_EXEC: w_next_state = S_DONE;
      S_MUL:  if (w_sub_done) w_next_state = S_DONE;
`ifdef ALU_EXEC_DIV_EN
      S_DIV:  if (w_sub_done) w_next_state = S_DONE;
`endif
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs and engine launch
  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    w_sub_start = (r_state == S_IDLE) && start &&
                  (w_next_state != S_EXEC) && (w_next_state != S_IDLE);
  end

  // Single-cycle operations on the latched operands
  always_comb begin
    w_rot_amt   = r_b[ROT_W-1:0];
    w_rot_inv   = C_ROT_SPAN - {1'b0, w_rot_amt};
    w_shift_big = (r_b >= C_SHIFT_LIM);
    w_exec_res  = '0;
    w_exec_hi   = '0;
    w_exec_err  = 1'b0;
    case (r_op)
      C_OP_ADD, C_OP_ADDA: w_exec_res = r_a + r_b;
      C_OP_SUB, C_OP_SUBB: w_exec_res = r_a - r_b;
      C_OP_SHL:  w_exec_res = w_shift_big ? '0 : (r_a << r_b[3:0]);
      C_OP_SHR:  w_exec_res = w_shift_big ? '0 : (r_a >> r_b[3:0]);
      C_OP_ROTL: w_exec_res = (r_a << w_rot_amt) | (r_a >> w_rot_inv);
      C_OP_ROTR: w_exec_res = (r_a >> w_rot_amt) | (r_a << w_rot_inv);
      C_OP_DIV: begin
`ifdef ALU_EXEC_DIV_EN
        // only reached with a zero divisor
        w_exec_res = '1;
        w_exec_hi  = r_a;
        w_exec_err = 1'b1;
`else
        w_exec_err = 1'b1;
`endif
      end
      default: w_exec_err = 1'b1;
    endcase
  end

  // Operand latch in IDLE and result capture on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= alu_control;
      end
      if (r_state == S_EXEC) begin
        r_result    <= w_exec_res;
        r_result_hi <= w_exec_hi;
        r_err       <= w_exec_err;
      end else if (w_sub_done) begin
        r_result    <= w_sub_lo;
        r_result_hi <= w_sub_hi;
        r_err       <= 1'b0;
      end
    end
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign err       = r_err;
  assign zero      = (r_result == '0);

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_sub_start),
`ifdef ALU_EXEC_DIV_EN
    .i_div   (w_sub_div),
`endif
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_sub_done),
    .o_lo    (w_sub_lo),
    .o_hi    (w_sub_hi)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module      : tb_alu_exec
// Description : Scoreboard bench for alu_exec (WIDTH=16). Expected results
//               are pushed when an operation is issued and popped when done
//               pulses. Divider cases follow ALU_EXEC_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        e;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_control = 4'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        zero;
  logic        busy;
  logic        done;
  logic        err;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t_start = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_exec #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    exp_t        m;
    logic [31:0] p;
    int          s;
    m.res = 16'd0; m.hi = 16'd0; m.e = 1'b0; m.lat = 2;
    s = int'(y[3:0]);
    case (op)
      4'd0, 4'd9:  m.res = x + y;
      4'd1, 4'd10: m.res = x - y;
      4'd3: begin
        p = {16'd0, x} * {16'd0, y};
        m.res = p[15:0]; m.hi = p[31:16]; m.lat = 17;
      end
      4'd4: begin
`ifdef ALU_EXEC_DIV_EN
        if (y == 16'd0) begin
          m.res = 16'hFFFF; m.hi = x; m.e = 1'b1;
        end else begin
          m.res = x / y; m.hi = x % y; m.lat = 17;
        end
`else
        m.e = 1'b1;
`endif
      end
      4'd5: m.res = (y >= 16'd16) ? 16'd0 : (x << s);
      4'd6: m.res = (y >= 16'd16) ? 16'd0 : (x >> s);
      4'd7: m.res = (x << s) | (x >> (16 - s));
      4'd8: m.res = (x >> s) | (x << (16 - s));
      default: m.e = 1'b1;
    endcase
    m.z = (m.res == 16'd0);
    return m;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending op
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result",    result,        mon_e.res);
        check("result_hi", result_hi,     mon_e.hi);
        check("zero",      zero,          mon_e.z);
        check("err",       err,           mon_e.e);
        check("latency",   cyc - t_start, mon_e.lat);
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                        input bit poke);
    exp_t e;
    int   n;
    e = model(op, av, bv);
    sb.push_back(e);
    @(negedge clk);
    a = av; b = bv; alu_control = op; start = 1'b1; t_start = cyc;
    n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      if (poke && n == 3) begin
        start = 1'b1; alu_control = 4'd0; a = 16'h1234; b = 16'h4321;
      end else begin
        start = 1'b0;
        if (n == 1) begin a = 16'($urandom); b = 16'($urandom); end
      end
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(negedge clk);
    check("hold_result", result, e.res);
    check("hold_hi",     result_hi, e.hi);
    check("hold_err",    err, e.e);
    check("done_pulse",  done, 1'b0);
  endtask

  initial begin
    logic [3:0] ops [12];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};

    repeat (3) @(negedge clk);
    check("rst_result",    result, 16'd0);
    check("rst_result_hi", result_hi, 16'd0);
    check("rst_busy",      busy, 1'b0);
    check("rst_done",      done, 1'b0);
    check("rst_err",       err, 1'b0);
    check("rst_zero",      zero, 1'b1);
    rst = 1'b0;

    run_op(4'd0,  16'h7FFF, 16'h0001, 1'b0);
    run_op(4'd1,  16'h0005, 16'h0007, 1'b0);
    run_op(4'd10, 16'h1234, 16'h1234, 1'b0);
    run_op(4'd9,  16'hFFFF, 16'h0003, 1'b0);
    run_op(4'd3,  16'h0100, 16'h0100, 1'b1);
    run_op(4'd3,  16'hFFFF, 16'hFFFF, 1'b0);
    run_op(4'd4,  16'd100,  16'd7,    1'b0);
    run_op(4'd4,  16'd100,  16'd0,    1'b0);
    run_op(4'd4,  16'd5,    16'd9,    1'b0);
    run_op(4'd7,  16'h8001, 16'd4,    1'b0);
    run_op(4'd5,  16'h8001, 16'd16,   1'b0);
    run_op(4'd5,  16'h0001, 16'd15,   1'b0);
    run_op(4'd6,  16'h8000, 16'd15,   1'b0);
    run_op(4'd8,  16'h0001, 16'd1,    1'b0);
    run_op(4'd7,  16'h00F1, 16'h0014, 1'b0);
    run_op(4'd2,  16'h1111, 16'h2222, 1'b0);
    run_op(4'd15, 16'h1111, 16'h2222, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_op(ops[$urandom_range(0, 11)], 16'($urandom),
             (i % 2 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom), 1'b0);
    end

    // Abort a multiply with reset part way through
    run_op(4'd0, 16'h0F00, 16'h00FF, 1'b0);
    @(negedge clk);
    a = 16'h0100; b = 16'h0100; alu_control = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_result",    result, 16'd0);
    check("abort_result_hi", result_hi, 16'd0);
    check("abort_busy",      busy, 1'b0);
    check("abort_done",      done, 1'b0);
    check("abort_err",       err, 1'b0);
    check("abort_zero",      zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    check("abort_idle_busy", busy, 1'b0);
    check("sb_empty",        sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; legal values 8 and 16 only.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  operation request, sampled only in IDLE.
REQ-005 Port: alu_control  input  4  operation code from the ALU control decoder.
REQ-006 Port: a  input  WIDTH  operand A (dividend, shift source).
REQ-007 Port: b  input  WIDTH  operand B (divisor); b[3:0] is the shift/rotate amount.
REQ-008 Port: result  output  WIDTH  primary result (sum, low product, quotient, shifted value).
REQ-009 Port: result_hi  output  WIDTH  high product half or division remainder; zero for all other ops.
REQ-010 Port: zero  output  1  high when result == 0.
REQ-011 Port: busy  output  1  high while an operation is in progress.
REQ-012 Port: done  output  1  one-cycle pulse marking result, result_hi, zero and err valid.
REQ-013 Port: err  output  1  illegal/unsupported code, or divide by zero.

Function
REQ-014 FSM states: IDLE, EXEC, MUL, DIV, DONE.
REQ-015 IDLE with start=1: latch a, b and alu_control; go to EXEC for single-cycle codes, MUL for 0011, DIV for 0100; busy=1 from the next cycle.
REQ-016 start while busy=1 (any state other than IDLE) is ignored; the latched operands are not disturbed.
REQ-017 Single-cycle codes: 0000 add, 0001 sub, 1001 add (address), 1010 sub (branch compare), 0101 shl, 0110 logical shr, 0111 rotl, 1000 rotr.
REQ-018 Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
REQ-019 Shift amounts >= WIDTH give 0 for shl/shr; rotate amounts are taken modulo WIDTH.
REQ-020 Codes 0010 and 1011-1111 are illegal: result=0, err=1, handled on the EXEC path.
REQ-021 EXEC lasts one cycle; done pulses in DONE, exactly 2 cycles after the start cycle.
REQ-022 MUL: unsigned shift-add, one bit per cycle, WIDTH cycles; result = low half, result_hi = high half; done WIDTH+1 cycles after the start cycle.
REQ-023 DIV: unsigned restoring, one bit per cycle, WIDTH cycles; result = quotient, result_hi = remainder; done WIDTH+1 cycles after the start cycle.
REQ-024 DIV with b=0: no iteration; result = all ones, result_hi = a, err=1; done 2 cycles after the start cycle.
REQ-025 DONE lasts one cycle, then returns to IDLE; start is sampled again in the cycle after done.
REQ-026 result, result_hi, zero and err hold their values after done until the next done.

Reset
REQ-027 On rst: state=IDLE; result, result_hi, busy, done and err are 0; zero=1.
REQ-028 rst during MUL/DIV aborts the operation; no done pulse is produced for it.

Configuration
REQ-029 Macro ALU_EXEC_DIV_EN defined: the DIV state and divider datapath are compiled in, per REQ-023/REQ-024.
REQ-030 ALU_EXEC_DIV_EN undefined: no DIV state; code 0100 is illegal per REQ-020, with done 2 cycles after the start cycle.

Structure
REQ-031 Shared package alu_pkg holds the 4-bit opcode constants (the same values the control decoder emits) and the FSM state enum.
REQ-032 The iterative mul/div engine is one sub-module, alu_seq_muldiv, with start/done handshake; alu_exec instantiates it.

Verification
REQ-033 a=16'h7FFF, b=16'h0001, code 0000 -> result 16'h8000, zero=0, err=0, done exactly 2 cycles after start.
REQ-034 a=16'h0100, b=16'h0100, code 0011 -> result 16'h0000, result_hi 16'h0001, zero=1, done at cycle 17.
REQ-035 a=16'd100, b=16'd7, code 0100 -> result 14, result_hi 2; b=0 -> result 16'hFFFF, result_hi 100, err=1, done at cycle 2.
REQ-036 a=16'h8001, b=4, code 0111 -> result 16'h0018; code 0101 with b=16 -> result 0.
REQ-037 Second start pulsed mid-MUL -> ignored, first result correct; rst at MUL cycle 5 -> no done, all outputs at reset values.
REQ-038 Code 0010 -> result 0, err=1, done at cycle 2; build without ALU_EXEC_DIV_EN, code 0100 -> err=1, done at cycle 2.
